cpu_dm_regs: RTL and testbench
==============================

Name: cpu_dm_regs

Overview:
- Parametrised successor of the CPU register/data-memory unit. Holds the Current Result (CR) accumulator and a new CR nesting stack for IEC 61131 IL parenthesised expressions.
- Latches APB write data.
- Fronts a byte-banked data memory with LANES lanes, adding a req/ready handshake, bit read-modify-write, sign extension and misalignment detection.
- Sits between the CPU sequencer/ALU and the APB master.

Parameters:
LANES, 4, byte lanes (4 or 8); DATA_W = 8*LANES
DM_ADDR_W, 10, DM bit-address width; [2:0] bit index, [2+log2(LANES):3] lane, upper bits row
STACK_DEPTH, 8, CR stack entries (2..16)

Ports:
cpu_clk  in  1  CPU clock, all logic on rising edge
cpu_reset  in  1  asynchronous, active-high reset
cr_en  in  1  load CR
cr_sel  in  1  CR source: 1 = prdata, 0 = alu_out_cr
prdata  in  DATA_W  APB read data
alu_out_cr  in  DATA_W  ALU result to CR
apb_en  in  1  latch CR into pwdata
cr_push  in  1  push CR onto stack
cr_pop  in  1  pop stack into CR
cr_out  out  DATA_W  CR value
pwdata  out  DATA_W  APB write data
stk_lvl  out  5  stack occupancy
stk_ovf  out  1  sticky overflow
stk_unf  out  1  sticky underflow
dm_req  in  1  DM access request
dm_wr  in  1  1 = write
dm_addr  in  DM_ADDR_W  bit address
dm_type  in  3  0 BIT, 1 BYTE, 2 WORD, 3 DWORD, 4 LWORD; 5-7 illegal
dm_sext  in  1  sign-extend read data
dm_wdata  in  DATA_W  write data, LSB-aligned
dm_ready  out  1  request accepted when dm_req & dm_ready
dm_rvalid  out  1  read data valid pulse
dm_rdata  out  DATA_W  read data, LSB-aligned
dm_err  out  1  illegal/misaligned pulse

Behaviour:
- Reset: cr_out, pwdata, stk_lvl, stk_ovf, stk_unf, dm_rvalid, dm_rdata, dm_err = 0; dm_ready = 1; FSM = IDLE. Memory and stack contents are not reset.
- pwdata: loads cr_out on apb_en, otherwise holds.
- CR priority: pop > cr_en.
  - cr_push and cr_pop together: stack no-op; cr_en is still honoured.
  - Push: stack[stk_lvl] <= CR, stk_lvl+1. cr_en in the same cycle loads CR normally (old CR is pushed).
  - Push at stk_lvl == STACK_DEPTH: nothing stored, stk_ovf <= 1.
  - Pop: CR <= stack[stk_lvl-1], stk_lvl-1.
  - Pop at stk_lvl == 0: CR unchanged, stk_unf <= 1.
  - stk_ovf and stk_unf clear only on reset.
- Alignment (lane = dm_addr lane field):
  - BIT and BYTE: any lane.
  - WORD: lane[0] = 0.
  - DWORD: lane[1:0] = 0.
  - LWORD: LANES = 8 and lane = 0.
  - Violations or types 5-7: access is accepted. Next cycle dm_err pulses one cycle; no write, no dm_rvalid.
- FSM states: IDLE, RMW_RD, RMW_WR.
- IDLE: dm_ready = 1.
  - Read: issued to the selected banks. Next cycle dm_rvalid = 1 with dm_rdata = selected bytes shifted to bit 0.
    - Upper bits zero-filled, or copied from the MSB of the accessed width when dm_sext = 1.
    - BIT reads return the bit in [0]; dm_sext is ignored for BIT.
  - BYTE/WORD/DWORD/LWORD write: committed at the accepting edge (one cycle). A read accepted the next cycle returns the new data.
  - BIT write: registers the address and bit, reads the byte, goes to RMW_RD.
- RMW_RD: dm_ready = 0. Merges dm_wdata[0] into bit dm_addr[2:0] of the read byte, goes to RMW_WR.
- RMW_WR: dm_ready = 0. Writes the merged byte, returns to IDLE. A bit write occupies 3 cycles.
- dm_req while dm_ready = 0 is ignored; the requester holds it.
- Reset mid-RMW aborts; the byte may be unwritten.
- dm_rvalid and dm_err are single-cycle pulses and mutually exclusive.

Test Plan:
- Reset, then cr_sel = 0, alu_out_cr = 0x12345678, cr_en -> cr_out = 0x12345678. apb_en -> pwdata = 0x12345678 next cycle.
- Push CR = 5, load 9, push, load 3, pop, pop -> cr_out 9 then 5, stk_lvl 2,1,0. An extra pop -> stk_unf = 1 and cr_out stays 5.
- 9 pushes with STACK_DEPTH = 8 -> stk_lvl = 8, stk_ovf = 1.
- Write BYTE 0x80 at lane 1, read BYTE with dm_sext = 1 -> dm_rdata = 0xFFFFFF80 (LANES = 4); with dm_sext = 0 -> 0x00000080.
- Over byte 0xA5, BIT write 1 at bit 1 -> dm_ready low for 2 cycles; BYTE read returns 0xA7. Back-to-back request held until dm_ready returns.
- WORD write at lane 1 -> dm_err pulse, memory unchanged. LWORD with LANES = 4 -> dm_err. LWORD round-trip with LANES = 8, value 0x0123456789ABCDEF -> identical readback.

Source files
------------

// File: rtl/cpu_dm_regs.sv
// CPU register unit: CR accumulator with nesting stack, APB write-data latch, and a
// byte-banked data memory front end with bit read-modify-write and alignment checks.
module cpu_dm_regs #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned DM_ADDR_W   = 10,
  parameter int unsigned STACK_DEPTH = 8,
  localparam int unsigned DATA_W     = 8 * LANES
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_reset,
  input  logic                 cr_en,
  input  logic                 cr_sel,
  input  logic [DATA_W-1:0]    prdata,
  input  logic [DATA_W-1:0]    alu_out_cr,
  input  logic                 apb_en,
  input  logic                 cr_push,
  input  logic                 cr_pop,
  output logic [DATA_W-1:0]    cr_out,
  output logic [DATA_W-1:0]    pwdata,
  output logic [4:0]           stk_lvl,
  output logic                 stk_ovf,
  output logic                 stk_unf,
  input  logic                 dm_req,
  input  logic                 dm_wr,
  input  logic [DM_ADDR_W-1:0] dm_addr,
  input  logic [2:0]           dm_type,
  input  logic                 dm_sext,
  input  logic [DATA_W-1:0]    dm_wdata,
  output logic                 dm_ready,
  output logic                 dm_rvalid,
  output logic [DATA_W-1:0]    dm_rdata,
  output logic                 dm_err
);
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned ROW_W  = DM_ADDR_W - 3 - LANE_W;
  localparam int unsigned ROWS   = 1 << ROW_W;
  localparam int unsigned STK_W  = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {StIdle, StRmwRd, StRmwWr} state_e;

  // ---------------- CR, stack, APB write data ----------------
  logic [DATA_W-1:0] cr_q, pw_q;
  logic [DATA_W-1:0] stack [STACK_DEPTH];
  logic [4:0]        lvl_q, lvl_dec;
  logic              ovf_q, unf_q, do_push, do_pop;

  assign do_push = cr_push & ~cr_pop;
  assign do_pop  = cr_pop & ~cr_push;
  assign lvl_dec = lvl_q - 5'd1;

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      cr_q  <= '0;
      pw_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (apb_en) pw_q <= cr_q;
      // An underflowing pop still blocks cr_en: pop has priority even when it fails.
      if (do_pop) begin
        if (lvl_q != 5'd0) begin
          cr_q  <= stack[lvl_dec[STK_W-1:0]];
          lvl_q <= lvl_dec;
        end else begin
          unf_q <= 1'b1;
        end
      end else if (cr_en) begin
        cr_q <= cr_sel ? prdata : alu_out_cr;
      end
      if (do_push) begin
        if (lvl_q < 5'(STACK_DEPTH)) lvl_q <= lvl_q + 5'd1;
        else                         ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (do_push && lvl_q < 5'(STACK_DEPTH)) stack[lvl_q[STK_W-1:0]] <= cr_q;
  end

  assign cr_out  = cr_q;
  assign pwdata  = pw_q;
  assign stk_lvl = lvl_q;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;

  // ---------------- Data memory front end ----------------
  logic [7:0]        mem [LANES][ROWS];
  logic [LANE_W-1:0] lane;
  logic [ROW_W-1:0]  row;
  logic [2:0]        bidx;
  int                nbytes;
  logic              legal, accept, sbit;
  logic [DATA_W-1:0] rd_raw, rd_ext;

  state_e            state_q;
  logic              ready_q, rvalid_q, err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [LANE_W-1:0] rmw_lane_q;
  logic [ROW_W-1:0]  rmw_row_q;
  logic [2:0]        rmw_bit_q;
  logic              rmw_wbit_q;
  logic [7:0]        rmw_byte_q;

  logic [LANES-1:0]  mem_we;
  logic [7:0]        mem_wd [LANES];
  logic [ROW_W-1:0]  mem_row;

  assign lane   = dm_addr[3+LANE_W-1:3];
  assign row    = dm_addr[DM_ADDR_W-1:3+LANE_W];
  assign bidx   = dm_addr[2:0];
  assign accept = dm_req & ready_q;

  always_comb begin
    nbytes = 1;
    legal  = 1'b1;
    case (dm_type)
      3'd0, 3'd1: nbytes = 1;
      3'd2: begin nbytes = 2; legal = ~lane[0]; end
      3'd3: begin nbytes = 4; legal = (lane[1:0] == 2'd0); end
      3'd4: begin nbytes = 8; legal = (LANES == 8) && (lane == '0); end
      default: legal = 1'b0;
    endcase
  end

  // Gather the accessed bytes LSB-aligned, then zero- or sign-fill above the access width.
  always_comb begin
    rd_raw = '0;
    sbit   = 1'b0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (k < nbytes && int'(lane) + k < int'(LANES)) begin
        rd_raw[8*k +: 8] = mem[int'(lane) + k][row];
      end
      if (k == nbytes - 1) sbit = rd_raw[8*k + 7];
    end
    rd_ext = rd_raw;
    if (dm_sext) begin
      for (int b = 0; b < int'(DATA_W); b++) begin
        if (b >= 8 * nbytes) rd_ext[b] = sbit;
      end
    end
    if (dm_type == 3'd0) begin
      rd_ext    = '0;
      rd_ext[0] = rd_raw[bidx];
    end
  end

  always_comb begin
    mem_we  = '0;
    mem_row = row;
    for (int l = 0; l < int'(LANES); l++) mem_wd[l] = '0;
    if (state_q == StRmwWr) begin
      mem_row             = rmw_row_q;
      mem_we[rmw_lane_q]  = 1'b1;
      mem_wd[rmw_lane_q]  = rmw_byte_q;
    end else if (accept && dm_wr && legal && dm_type != 3'd0) begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (l >= int'(lane) && l < int'(lane) + nbytes) begin
          mem_we[l] = 1'b1;
          mem_wd[l] = dm_wdata[8*(l - int'(lane)) +: 8];
        end
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    for (int l = 0; l < int'(LANES); l++) begin
      if (mem_we[l]) mem[l][mem_row] <= mem_wd[l];
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      state_q    <= StIdle;
      ready_q    <= 1'b1;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      rmw_lane_q <= '0;
      rmw_row_q  <= '0;
      rmw_bit_q  <= '0;
      rmw_wbit_q <= 1'b0;
      rmw_byte_q <= '0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (!legal) begin
              err_q <= 1'b1;
            end else if (!dm_wr) begin
              rvalid_q <= 1'b1;
              rdata_q  <= rd_ext;
            end else if (dm_type == 3'd0) begin
              // Write bit is captured here so the requester may change dm_wdata.
              rmw_lane_q <= lane;
              rmw_row_q  <= row;
              rmw_bit_q  <= bidx;
              rmw_wbit_q <= dm_wdata[0];
              rmw_byte_q <= rd_raw[7:0];
              ready_q    <= 1'b0;
              state_q    <= StRmwRd;
            end
          end
        end
        StRmwRd: begin
          rmw_byte_q[rmw_bit_q] <= rmw_wbit_q;
          state_q               <= StRmwWr;
        end
        StRmwWr: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign dm_ready  = ready_q;
  assign dm_rvalid = rvalid_q;
  assign dm_rdata  = rdata_q;
  assign dm_err    = err_q;

endmodule

// File: tb/tb_cpu_dm_regs.sv
// Self-checking bench for cpu_dm_regs: directed steps plus random traffic against a
// flat byte-array memory model and a queue-based CR stack model.
module tb_cpu_dm_regs;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cr_en, cr_sel, cr_push, cr_pop, apb_en;
  logic [31:0] prdata, alu_out_cr, cr_out, pwdata;
  logic [4:0]  stk_lvl;
  logic        stk_ovf, stk_unf;
  logic        req4, wr4, sext4, rdy4, rv4, err4;
  logic [9:0]  addr4;
  logic [2:0]  typ4;
  logic [31:0] wd4, rd4;

  logic        req8, wr8, sext8, rdy8, rv8, err8;
  logic [9:0]  addr8;
  logic [2:0]  typ8;
  logic [63:0] wd8, rd8, cr_out8, pwdata8;
  logic [4:0]  lvl8;
  logic        ovf8, unf8;

  cpu_dm_regs #(.LANES(4), .DM_ADDR_W(10), .STACK_DEPTH(8)) u4 (
    .cpu_clk(clk), .cpu_reset(rst), .cr_en(cr_en), .cr_sel(cr_sel), .prdata(prdata),
    .alu_out_cr(alu_out_cr), .apb_en(apb_en), .cr_push(cr_push), .cr_pop(cr_pop),
    .cr_out(cr_out), .pwdata(pwdata), .stk_lvl(stk_lvl), .stk_ovf(stk_ovf), .stk_unf(stk_unf),
    .dm_req(req4), .dm_wr(wr4), .dm_addr(addr4), .dm_type(typ4), .dm_sext(sext4),
    .dm_wdata(wd4), .dm_ready(rdy4), .dm_rvalid(rv4), .dm_rdata(rd4), .dm_err(err4)
  );

  cpu_dm_regs #(.LANES(8), .DM_ADDR_W(10), .STACK_DEPTH(8)) u8 (
    .cpu_clk(clk), .cpu_reset(rst), .cr_en(1'b0), .cr_sel(1'b0), .prdata(64'h0),
    .alu_out_cr(64'h0), .apb_en(1'b0), .cr_push(1'b0), .cr_pop(1'b0),
    .cr_out(cr_out8), .pwdata(pwdata8), .stk_lvl(lvl8), .stk_ovf(ovf8), .stk_unf(unf8),
    .dm_req(req8), .dm_wr(wr8), .dm_addr(addr8), .dm_type(typ8), .dm_sext(sext8),
    .dm_wdata(wd8), .dm_ready(rdy8), .dm_rvalid(rv8), .dm_rdata(rd8), .dm_err(err8)
  );

  int tests = 0;
  int fails = 0;

  // Reference state
  logic [7:0]  mem4 [128];
  logic [7:0]  mem8 [128];
  logic [31:0] cr_m, pw_m;
  logic [31:0] stk_q [$];
  bit          ovf_m, unf_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_legal(bit big, logic [2:0] typ, logic [9:0] addr);
    int lanes = big ? 8 : 4;
    int ln = int'(addr >> 3) % lanes;
    case (typ)
      3'd0, 3'd1: return 1'b1;
      3'd2:       return (ln % 2) == 0;
      3'd3:       return (ln % 4) == 0;
      3'd4:       return big && ln == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] model_read(bit big, logic [2:0] typ, logic [9:0] addr,
                                             bit sext);
    int ba = int'(addr >> 3);
    int n;
    logic [63:0] v = '0;
    logic [7:0] b;
    if (typ == 3'd0) begin
      b = big ? mem8[ba] : mem4[ba];
      v[0] = b[addr[2:0]];
      return v;
    end
    n = 1 << (int'(typ) - 1);
    for (int k = 0; k < n; k++) v[8*k +: 8] = big ? mem8[ba + k] : mem4[ba + k];
    if (sext && n < 8 && v[8*n - 1]) v = v | (~64'h0 << (8 * n));
    if (!big) v[63:32] = '0;
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic dm_op(input bit big, input bit wr, input logic [2:0] typ,
                       input logic [9:0] addr, input bit sext, input logic [63:0] wdata,
                       output int nwait, output logic [63:0] rd);
    bit legal, g_rv, g_err, g_rdy;
    logic [63:0] exp;
    int ba;
    if (big) begin req8 = 1; wr8 = wr; typ8 = typ; addr8 = addr; sext8 = sext; wd8 = wdata; end
    else begin req4 = 1; wr4 = wr; typ4 = typ; addr4 = addr; sext4 = sext; wd4 = wdata[31:0]; end
    nwait = 0;
    while ((big ? rdy8 : rdy4) !== 1'b1 && nwait < 8) begin
      @(negedge clk);
      nwait++;
    end
    check("ready_wait_bounded", 64'(nwait < 8), 64'd1);
    @(posedge clk);
    @(negedge clk);
    if (big) begin req8 = 0; g_rv = rv8; g_err = err8; g_rdy = rdy8; rd = rd8; end
    else begin req4 = 0; g_rv = rv4; g_err = err4; g_rdy = rdy4; rd = 64'(rd4); end
    legal = model_legal(big, typ, addr);
    check("dm_err", 64'(g_err), 64'(!legal));
    check("dm_rvalid", 64'(g_rv), 64'(legal && !wr));
    if (legal && !wr) begin
      exp = model_read(big, typ, addr, sext);
      check("dm_rdata", rd, exp);
    end
    if (legal && wr) begin
      ba = int'(addr >> 3);
      if (typ == 3'd0) begin
        check("rmw_ready_low", 64'(g_rdy), 64'd0);
        if (big) mem8[ba][addr[2:0]] = wdata[0]; else mem4[ba][addr[2:0]] = wdata[0];
      end else begin
        for (int k = 0; k < (1 << (int'(typ) - 1)); k++) begin
          if (big) mem8[ba + k] = wdata[8*k +: 8]; else mem4[ba + k] = wdata[8*k +: 8];
        end
      end
    end
  endtask

  task automatic cr_step(input bit en, input bit sel, input bit push, input bit pop,
                         input bit apb, input logic [31:0] alu, input logic [31:0] prd);
    @(negedge clk);
    cr_en = en; cr_sel = sel; cr_push = push; cr_pop = pop; apb_en = apb;
    alu_out_cr = alu; prdata = prd;
    @(posedge clk);
    @(negedge clk);
    cr_en = 0; cr_push = 0; cr_pop = 0; apb_en = 0;
    if (apb) pw_m = cr_m;
    if (push && !pop) begin
      if (stk_q.size() < 8) stk_q.push_back(cr_m);
      else ovf_m = 1;
    end
    if (pop && !push) begin
      if (stk_q.size() > 0) cr_m = stk_q.pop_back();
      else unf_m = 1;
    end else if (en) begin
      cr_m = sel ? prd : alu;
    end
    check("cr_out", 64'(cr_out), 64'(cr_m));
    check("pwdata", 64'(pwdata), 64'(pw_m));
    check("stk_lvl", 64'(stk_lvl), 64'(stk_q.size()));
    check("stk_ovf", 64'(stk_ovf), 64'(ovf_m));
    check("stk_unf", 64'(stk_unf), 64'(unf_m));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    logic [63:0] rd;
    cr_en = 0; cr_sel = 0; cr_push = 0; cr_pop = 0; apb_en = 0; prdata = 0; alu_out_cr = 0;
    req4 = 0; wr4 = 0; sext4 = 0; addr4 = 0; typ4 = 0; wd4 = 0;
    req8 = 0; wr8 = 0; sext8 = 0; addr8 = 0; typ8 = 0; wd8 = 0;
    cr_m = 0; pw_m = 0; ovf_m = 0; unf_m = 0;
    repeat (3) @(negedge clk);
    check("rst_cr_out", 64'(cr_out), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_stk_lvl", 64'(stk_lvl), 64'd0);
    check("rst_ovf_unf", {62'd0, stk_ovf, stk_unf}, 64'd0);
    check("rst_dm_ready", 64'(rdy4), 64'd1);
    check("rst_dm_pulses", {62'd0, rv4, err4}, 64'd0);
    check("rst_dm_rdata", 64'(rd4), 64'd0);
    rst = 0;

    // CR load and APB latch
    cr_step(1, 0, 0, 0, 0, 32'h1234_5678, 32'h0);
    check("cr_load", 64'(cr_out), 64'h1234_5678);
    cr_step(0, 0, 0, 0, 1, 32'h0, 32'h0);
    check("pwdata_latch", 64'(pwdata), 64'h1234_5678);
    cr_step(1, 1, 0, 0, 0, 32'h0, 32'hCAFE_0001);

    // Nesting: push 5, load 9, push, load 3, pop, pop, underflow
    cr_step(1, 0, 0, 0, 0, 32'd5, 32'h0);
    cr_step(0, 0, 1, 0, 0, 32'h0, 32'h0);
    cr_step(1, 0, 0, 0, 0, 32'd9, 32'h0);
    cr_step(0, 0, 1, 0, 0, 32'h0, 32'h0);
    cr_step(1, 0, 0, 0, 0, 32'd3, 32'h0);
    cr_step(0, 0, 0, 1, 0, 32'h0, 32'h0);
    check("pop_first", 64'(cr_out), 64'd9);
    cr_step(1, 0, 0, 1, 0, 32'd77, 32'h0);
    check("pop_second", 64'(cr_out), 64'd5);
    cr_step(1, 0, 0, 1, 0, 32'd77, 32'h0);
    check("unf_cr_kept", 64'(cr_out), 64'd5);
    check("unf_set", 64'(stk_unf), 64'd1);
    cr_step(1, 0, 1, 1, 0, 32'd44, 32'h0);
    for (int i = 0; i < 9; i++) cr_step(1, 0, 1, 0, 0, 32'(i + 100), 32'h0);
    check("ovf_lvl", 64'(stk_lvl), 64'd8);
    check("ovf_set", 64'(stk_ovf), 64'd1);
    for (int i = 0; i < 150; i++) begin
      cr_step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom, $urandom);
    end

    // Fill DM with known bytes
    for (int b = 0; b < 128; b++) dm_op(0, 1, 3'd1, 10'(b << 3), 0, 64'($urandom), nw, rd);

    // Sign extension of a BYTE at lane 1
    dm_op(0, 1, 3'd1, 10'd8, 0, 64'h80, nw, rd);
    dm_op(0, 0, 3'd1, 10'd8, 1, 64'h0, nw, rd);
    check("byte_sext", rd, 64'hFFFF_FF80);
    dm_op(0, 0, 3'd1, 10'd8, 0, 64'h0, nw, rd);
    check("byte_zext", rd, 64'h80);

    // Bit RMW followed by a held back-to-back read
    dm_op(0, 1, 3'd1, 10'd40, 0, 64'hA5, nw, rd);
    dm_op(0, 1, 3'd0, 10'd41, 0, 64'h1, nw, rd);
    dm_op(0, 0, 3'd1, 10'd40, 0, 64'h0, nw, rd);
    check("b2b_wait", 64'(nw), 64'd2);
    check("rmw_byte", rd, 64'hA7);

    // Misaligned WORD, LWORD on a 4-lane build
    dm_op(0, 1, 3'd2, 10'd72, 0, 64'hBEEF, nw, rd);
    dm_op(0, 0, 3'd1, 10'd72, 0, 64'h0, nw, rd);
    dm_op(0, 0, 3'd1, 10'd80, 0, 64'h0, nw, rd);
    dm_op(0, 1, 3'd4, 10'd0, 0, 64'h1, nw, rd);
    dm_op(0, 0, 3'd5, 10'd0, 0, 64'h0, nw, rd);

    // 8-lane LWORD round trip and a sign-extended DWORD
    dm_op(1, 1, 3'd4, 10'd64, 0, 64'h0123_4567_89AB_CDEF, nw, rd);
    dm_op(1, 0, 3'd4, 10'd64, 0, 64'h0, nw, rd);
    check("lword_rt", rd, 64'h0123_4567_89AB_CDEF);
    dm_op(1, 0, 3'd3, 10'd64, 1, 64'h0, nw, rd);
    dm_op(1, 1, 3'd4, 10'd72, 0, 64'h5, nw, rd);

    // Random traffic on the 4-lane build
    for (int i = 0; i < 400; i++) begin
      dm_op(0, 1'($urandom), 3'($urandom_range(0, 7)), 10'($urandom), 1'($urandom),
            64'($urandom), nw, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
